// File: rtl/vedic_4x4_sequencer.sv
// Multi-cycle unsigned 4x4 -> 8-bit multiplier sequencer. Issues the four
// 2-bit partial products to one external registered 2x2 multiplier, waits
// PP_LATENCY edges for each, then shifts and accumulates the result.
module vedic_4x4_sequencer #(
    parameter int unsigned PP_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_product,
    output logic       busy,
    output logic       pp_en,
    output logic [1:0] pp_mul_1,
    output logic [1:0] pp_mul_2,
    input  logic [4:0] pp_product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAT = 3'(PP_LATENCY);

    state_t     state_q, state_d;
    logic [1:0] k_q, k_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] acc_q, acc_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [7:0] prod_q, prod_d;

    logic [2:0] shift;
    logic [7:0] partial;
    logic [7:0] acc_sum;

    // The 2x2 product never exceeds 9, so its top bit carries no information.
    logic unused_pp_msb;
    assign unused_pp_msb = pp_product[4];

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
        end
    end

    // Step selection: operand halves and weight of the current partial product.
    always_comb begin
        shift   = '0;
        partial = '0;
        unique case (k_q)
            2'd0: shift = 3'd0;
            2'd1: shift = 3'd2;
            2'd2: shift = 3'd2;
            2'd3: shift = 3'd4;
            default: shift = 3'd0;
        endcase
        partial = {4'b0000, pp_product[3:0]} << shift;
        acc_sum = acc_q + partial;
    end

    // Next-state, handshake outputs and 2x2 operand drive.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        prod_d    = prod_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        pp_en     = 1'b0;
        pp_mul_1  = '0;
        pp_mul_2  = '0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                busy     = 1'b1;
                pp_en    = 1'b1;
                pp_mul_1 = k_q[0] ? a_q[3:2] : a_q[1:0];
                pp_mul_2 = k_q[1] ? b_q[3:2] : b_q[1:0];
                if (cnt_q == LAT) begin
                    acc_d = acc_sum;
                    cnt_d = '0;
                    if (k_q == 2'd3) begin
                        prod_d  = acc_sum;
                        state_d = DONE;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_product = prod_q;

endmodule

// File: tb/tb_vedic_4x4_sequencer.sv
// Self-checking bench: directed plan steps plus random operand pairs, checked
// against plain a*b and the partial-product schedule; a second instance runs
// with PP_LATENCY=3 against a 3-stage 2x2 model.
module tb_vedic_4x4_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    int         checks = 0;
    int         errors = 0;

    // PP_LATENCY = 1 instance
    logic       in_valid, in_ready, out_valid, out_ready, busy, pp_en;
    logic [3:0] in_a, in_b;
    logic [7:0] out_product;
    logic [1:0] pp_mul_1, pp_mul_2;
    logic [4:0] pp_product;

    // PP_LATENCY = 3 instance
    logic       in_valid3, in_ready3, out_valid3, out_ready3, busy3, pp_en3;
    logic [3:0] in_a3, in_b3;
    logic [7:0] out_product3;
    logic [1:0] pp_mul_13, pp_mul_23;
    logic [4:0] pp_product3;
    logic [4:0] stage3 [3];

    always #5 clk = ~clk;

    vedic_4x4_sequencer #(.PP_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .busy(busy), .pp_en(pp_en), .pp_mul_1(pp_mul_1), .pp_mul_2(pp_mul_2),
        .pp_product(pp_product)
    );

    vedic_4x4_sequencer #(.PP_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_a(in_a3), .in_b(in_b3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_product(out_product3),
        .busy(busy3), .pp_en(pp_en3), .pp_mul_1(pp_mul_13), .pp_mul_2(pp_mul_23),
        .pp_product(pp_product3)
    );

    // 2x2 multiplier models; bit 4 is random garbage the DUT must ignore.
    always @(posedge clk) begin
        pp_product <= {1'($urandom), 4'(4'(pp_mul_1) * 4'(pp_mul_2))};
        stage3[0]  <= {1'($urandom), 4'(4'(pp_mul_13) * 4'(pp_mul_23))};
        stage3[1]  <= stage3[0];
        stage3[2]  <= stage3[1];
    end
    assign pp_product3 = stage3[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Operand halves for step k: k0 A.lo*B.lo, k1 A.hi*B.lo, k2 A.lo*B.hi, k3 A.hi*B.hi
    function automatic logic [1:0] exp_op_a(input logic [3:0] a, input int k);
        return (k == 1 || k == 3) ? a[3:2] : a[1:0];
    endfunction
    function automatic logic [1:0] exp_op_b(input logic [3:0] b, input int k);
        return (k >= 2) ? b[3:2] : b[1:0];
    endfunction

    // Full transaction on the PP_LATENCY=1 instance; hold = cycles out_ready stays low.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int hold);
        int m;
        int w;
        logic [7:0] exp;
        exp = 8'(a) * 8'(b);
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        @(posedge clk);
        @(negedge clk);
        // garbage request while busy must be ignored
        in_a = 4'($urandom);
        in_b = 4'($urandom);
        m = 0;
        while (!out_valid && m < 40) begin
            chk("mul_in_ready", 32'(in_ready), 32'd0);
            chk("mul_pp_en", 32'(pp_en), 32'd1);
            if (m < 8) begin
                chk("pp_mul_1", 32'(pp_mul_1), 32'(exp_op_a(a, m / 2)));
                chk("pp_mul_2", 32'(pp_mul_2), 32'(exp_op_b(b, m / 2)));
            end
            @(negedge clk);
            m++;
        end
        chk("latency", 32'(m), 32'd8);
        chk("product", 32'(out_product), 32'(exp));
        chk("done_pp_en", 32'(pp_en), 32'd0);
        chk("done_ops", 32'({pp_mul_1, pp_mul_2}), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_product", 32'(out_product), 32'(exp));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        // in_valid was high at the handshake edge: must not have been accepted
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
        chk("post_hs_busy", 32'(busy), 32'd0);
        chk("post_hs_product", 32'(out_product), 32'(exp));
        in_valid = 1'b0;
    endtask

    initial begin
        int seen;
        int m;
        logic [3:0] ra, rb;
        logic [7:0] exp3;

        reset = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        in_valid3 = 1'b0; in_a3 = '0; in_b3 = '0; out_ready3 = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_product", 32'(out_product), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pp_en", 32'(pp_en), 32'd0);
        chk("rst_ops", 32'({pp_mul_1, pp_mul_2}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        run_op(4'd1, 4'd1, 0);
        run_op(4'd15, 4'd15, 0);
        run_op(4'd6, 4'd9, 5);
        run_op(4'd0, 4'd13, 0);
        run_op(4'd10, 4'd3, 0);

        // Reset mid-operation at step k=2 of 7*7
        @(negedge clk);
        in_valid = 1'b1; in_a = 4'd7; in_b = 4'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_k2_op_a", 32'(pp_mul_1), 32'd3);
        chk("pre_rst_k2_op_b", 32'(pp_mul_2), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_product", 32'(out_product), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_pp_en", 32'(pp_en), 32'd0);
        chk("abort_ops", 32'({pp_mul_1, pp_mul_2}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        run_op(4'd2, 4'd5, 0);

        // Random operand pairs
        for (int i = 0; i < 20; i++) begin
            run_op(4'($urandom), 4'($urandom), $urandom_range(0, 3));
        end

        // PP_LATENCY = 3 instance
        for (int i = 0; i < 4; i++) begin
            ra = (i == 0) ? 4'd12 : 4'($urandom);
            rb = (i == 0) ? 4'd11 : 4'($urandom);
            exp3 = 8'(ra) * 8'(rb);
            @(negedge clk);
            chk("l3_in_ready", 32'(in_ready3), 32'd1);
            in_valid3 = 1'b1; in_a3 = ra; in_b3 = rb;
            @(posedge clk);
            @(negedge clk);
            in_valid3 = 1'b0;
            m = 0;
            while (!out_valid3 && m < 80) begin
                @(negedge clk);
                m++;
            end
            chk("l3_latency", 32'(m), 32'd16);
            chk("l3_product", 32'(out_product3), 32'(exp3));
            out_ready3 = 1'b1;
            @(negedge clk);
            out_ready3 = 1'b0;
            chk("l3_post_hs_valid", 32'(out_valid3), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
